// File: rtl/gpu_cmd_pkg.sv
// Shared encodings and record-width helpers for the GPU command queue.
package gpu_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT
    } disp_state_e;

    typedef enum logic {
        CMD_DRAW  = 1'b0,
        CMD_CLEAR = 1'b1
    } cmd_type_e;

    localparam int unsigned FB_WIDTH_DEF  = 400;
    localparam int unsigned FB_HEIGHT_DEF = 240;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned FIELD_W       = 16;

    // Geometry fields carry two spare bits over the framebuffer dimension.
    function automatic int unsigned geom_w(input int unsigned dim);
        return $clog2(dim) + 2;
    endfunction

    // Packed record: type, address, 4x16-bit fields, width, height, x, y.
    function automatic int unsigned rec_w(input int unsigned fbw, input int unsigned fbh);
        return 1 + ADDR_W + 4 * FIELD_W + 2 * geom_w(fbw) + 2 * geom_w(fbh);
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Command FIFO: registered storage, wrapping pointers and registered level.
module gpu_cmd_fifo
    import gpu_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Head is read from registered storage, so a push is visible only next cycle.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/gpu_cmd_queue.sv
// GPU command queue: host FIFO feeding a SETUP/STROBE/WAIT dispatch FSM.
module gpu_cmd_queue
    import gpu_cmd_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_type,
    input  logic [31:0]                   cmd_address,
    input  logic [15:0]                   cmd_address_x,
    input  logic [15:0]                   cmd_address_y,
    input  logic [15:0]                   cmd_image_width,
    input  logic [15:0]                   cmd_clear_color,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_width,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_height,
    input  logic [$clog2(FB_WIDTH)+1:0]   cmd_x,
    input  logic [$clog2(FB_HEIGHT)+1:0]  cmd_y,
    output logic [31:0]                   ctrl_address,
    output logic [15:0]                   ctrl_address_x,
    output logic [15:0]                   ctrl_address_y,
    output logic [15:0]                   ctrl_image_width,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_width,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_height,
    output logic [$clog2(FB_WIDTH)+1:0]   ctrl_x,
    output logic [$clog2(FB_HEIGHT)+1:0]  ctrl_y,
    output logic [15:0]                   ctrl_clear_color,
    output logic                          ctrl_draw,
    output logic                          ctrl_clear,
    input  logic                          ctrl_busy,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          idle,
    output logic                          cmd_done
);

    localparam int unsigned RW = rec_w(FB_WIDTH, FB_HEIGHT);

    disp_state_e    state_q, state_d;
    logic [RW-1:0]  push_rec, head_rec;
    logic [RW-1:0]  ctrl_rec_q, ctrl_rec_d;
    logic           cmd_done_q, cmd_done_d;
    logic           pop, fifo_full, fifo_empty;
    logic           ctrl_type;

    assign push_rec = {cmd_type, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
                       cmd_clear_color, cmd_width, cmd_height, cmd_x, cmd_y};

    gpu_cmd_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (cmd_valid),
        .wdata_i (push_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_rec_q <= '0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_rec_q <= ctrl_rec_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    // Control fields are loaded only on the pop edge and held until the next one.
    always_comb begin
        state_d    = state_q;
        ctrl_rec_d = ctrl_rec_q;
        cmd_done_d = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !ctrl_busy) begin
                    pop        = 1'b1;
                    ctrl_rec_d = head_rec;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!ctrl_busy) begin
                    state_d    = ST_IDLE;
                    cmd_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign {ctrl_type, ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
            ctrl_clear_color, ctrl_width, ctrl_height, ctrl_x, ctrl_y} = ctrl_rec_q;

    always_comb begin
        ctrl_draw  = (state_q == ST_STROBE) && (ctrl_type == CMD_DRAW);
        ctrl_clear = (state_q == ST_STROBE) && (ctrl_type == CMD_CLEAR);
        idle       = (state_q == ST_IDLE) && fifo_empty;
        cmd_done   = cmd_done_q;
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_gpu_cmd_queue;

    localparam int unsigned FBW   = 400;
    localparam int unsigned FBH   = 240;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XW    = $clog2(FBW) + 2;
    localparam int unsigned YW    = $clog2(FBH) + 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          t;
        logic [31:0]   addr;
        logic [15:0]   ax, ay, iw, color;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid = 1'b0;
    logic          ctrl_busy = 1'b0;
    cmd_t          drv = '0;
    logic          cmd_ready, ctrl_draw, ctrl_clear, idle, cmd_done;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [XW-1:0] ctrl_width, ctrl_x;
    logic [YW-1:0] ctrl_height, ctrl_y;
    logic [LW-1:0] level;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    gpu_cmd_queue #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(drv.t), .cmd_address(drv.addr), .cmd_address_x(drv.ax),
        .cmd_address_y(drv.ay), .cmd_image_width(drv.iw), .cmd_clear_color(drv.color),
        .cmd_width(drv.w), .cmd_height(drv.h), .cmd_x(drv.x), .cmd_y(drv.y),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
        .ctrl_clear_color(ctrl_clear_color), .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
        .ctrl_busy(ctrl_busy), .level(level), .idle(idle), .cmd_done(cmd_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command queue plus the age of the in-flight command.
    // Age 0 is the setup cycle, age 1 the strobe cycle, age >= 2 waiting on busy.
    cmd_t        mq[$];
    cmd_t        m_ctrl = '0;
    bit          m_active = 1'b0;
    int unsigned m_age = 0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ctrl   = '0;
            m_active = 1'b0;
            m_age    = 0;
            m_done   = 1'b0;
        end else begin
            bit can_pop, can_push;
            can_pop  = !m_active && (mq.size() != 0) && !ctrl_busy;
            can_push = cmd_valid && (mq.size() < DEPTH);
            m_done   = 1'b0;
            if (m_active) begin
                if (m_age >= 2 && !ctrl_busy) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if (m_age < 2) begin
                    m_age++;
                end
            end
            if (can_pop) begin
                m_ctrl   = mq.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end
            if (can_push) mq.push_back(drv);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_level", level, mq.size());
            chk("m_ready", cmd_ready, mq.size() != DEPTH);
            chk("m_idle", idle, !m_active && mq.size() == 0);
            chk("m_draw", ctrl_draw, m_active && m_age == 1 && m_ctrl.t == 1'b0);
            chk("m_clear", ctrl_clear, m_active && m_age == 1 && m_ctrl.t == 1'b1);
            chk("m_done", cmd_done, m_done);
            chk("m_addr", ctrl_address, m_ctrl.addr);
            chk("m_ax", ctrl_address_x, m_ctrl.ax);
            chk("m_ay", ctrl_address_y, m_ctrl.ay);
            chk("m_iw", ctrl_image_width, m_ctrl.iw);
            chk("m_color", ctrl_clear_color, m_ctrl.color);
            chk("m_w", ctrl_width, m_ctrl.w);
            chk("m_h", ctrl_height, m_ctrl.h);
            chk("m_x", ctrl_x, m_ctrl.x);
            chk("m_y", ctrl_y, m_ctrl.y);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic cmd_t mk(input logic t, input logic [31:0] a, input logic [15:0] color);
        cmd_t c;
        c       = '0;
        c.t     = t;
        c.addr  = a;
        c.ax    = a[15:0] ^ 16'h00A5;
        c.ay    = 16'h0033;
        c.iw    = 16'd320;
        c.color = color;
        c.w     = XW'(16);
        c.h     = YW'(8);
        c.x     = XW'(10);
        c.y     = YW'(20);
        return c;
    endfunction

    function automatic cmd_t rnd();
        cmd_t c;
        c.t     = 1'($urandom_range(0, 1));
        c.addr  = $urandom;
        c.ax    = 16'($urandom);
        c.ay    = 16'($urandom);
        c.iw    = 16'($urandom);
        c.color = 16'($urandom);
        c.w     = XW'($urandom);
        c.h     = YW'($urandom);
        c.x     = XW'($urandom);
        c.y     = YW'($urandom);
        return c;
    endfunction

    task automatic wait_strobe(input string name, input int unsigned max);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!(ctrl_draw || ctrl_clear) && n < max);
        chk(name, ctrl_draw || ctrl_clear, 1);
    endtask

    task automatic drain_order(input string name, input logic [31:0] base, input int unsigned cnt);
        int unsigned n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            chk({name, "_overlap"}, ctrl_draw && ctrl_clear, 0);
            if (ctrl_draw || ctrl_clear) begin
                chk($sformatf("%s_order%0d", name, n), ctrl_address, base + n);
                n++;
            end
        end
        chk({name, "_count"}, n, cnt);
    endtask

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) step();
        chk("rst_level", level, 0);
        chk("rst_addr", ctrl_address, 0);
        chk("rst_draw", ctrl_draw, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_idle", idle, 1);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        step();
        chk("rst_ready", cmd_ready, 1);

        // Single draw: latency and payload.
        drv = mk(1'b0, 32'h1000, 16'h0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("lat_level_t0", level, 1);
        chk("lat_addr_t0", ctrl_address, 0);
        step();
        chk("lat_addr_t1", ctrl_address, 32'h1000);
        chk("lat_w_t1", ctrl_width, 16);
        chk("lat_h_t1", ctrl_height, 8);
        chk("lat_x_t1", ctrl_x, 10);
        chk("lat_y_t1", ctrl_y, 20);
        chk("lat_draw_t1", ctrl_draw, 0);
        step();
        chk("lat_draw_t2", ctrl_draw, 1);
        chk("lat_clear_t2", ctrl_clear, 0);
        ctrl_busy = 1'b1;
        step();
        chk("lat_draw_t3", ctrl_draw, 0);
        step();
        step();
        chk("lat_done_busy", cmd_done, 0);
        ctrl_busy = 1'b0;
        step();
        chk("lat_done", cmd_done, 1);
        chk("lat_idle", idle, 1);
        step();
        chk("lat_done_pulse", cmd_done, 0);

        // Overfill with GPU busy: only DEPTH accepted.
        ctrl_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drv = mk(1'($urandom_range(0, 1)), 32'h2000 + i, 16'($urandom));
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        chk("full_level", level, DEPTH);
        chk("full_ready", cmd_ready, 0);
        ctrl_busy = 1'b0;
        drain_order("full", 32'h2000, 4);

        // Clear queued behind a draw.
        drv = mk(1'b0, 32'h3000, 16'h0);
        cmd_valid = 1'b1;
        step();
        drv = mk(1'b1, 32'h3001, 16'hF801);
        step();
        cmd_valid = 1'b0;
        wait_strobe("clr_draw_strobe", 10);
        chk("clr_first_is_draw", ctrl_draw, 1);
        ctrl_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("clr_held_off", ctrl_clear, 0);
        end
        ctrl_busy = 1'b0;
        wait_strobe("clr_strobe", 20);
        chk("clr_pulse", ctrl_clear, 1);
        chk("clr_color", ctrl_clear_color, 16'hF801);
        ctrl_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_color_hold", ctrl_clear_color, 16'hF801);
        end
        ctrl_busy = 1'b0;
        step();
        chk("clr_done", cmd_done, 1);
        chk("clr_color_after", ctrl_clear_color, 16'hF801);

        // Simultaneous push and pop at level 2.
        ctrl_busy = 1'b1;
        drv = mk(1'b0, 32'h4000, 16'h0);
        cmd_valid = 1'b1;
        step();
        drv = mk(1'b1, 32'h4001, 16'h1234);
        step();
        chk("pp_level_pre", level, 2);
        drv = mk(1'b0, 32'h4002, 16'h0);
        ctrl_busy = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("pp_level", level, 2);
        chk("pp_head", ctrl_address, 32'h4000);
        step();
        drain_order("pp", 32'h4001, 2);

        // Reset while waiting with three queued.
        drv = mk(1'b0, 32'h5000, 16'h0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_strobe("rw_strobe", 10);
        ctrl_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv = mk(1'b1, 32'h5001 + i, 16'hBEEF);
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        chk("rw_level_pre", level, 3);
        #2 reset = 1'b1;
        #1;
        chk("rw_level", level, 0);
        chk("rw_addr", ctrl_address, 0);
        chk("rw_idle", idle, 1);
        step();
        #2 reset = 1'b0;
        ctrl_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rw_no_strobe", ctrl_draw || ctrl_clear, 0);
            chk("rw_idle_after", idle, 1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drv = rnd();
            cmd_valid = ($urandom_range(0, 99) < 55);
            ctrl_busy = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 400, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 240, framebuffer height in pixels.
REQ-003 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-004 SHALL have clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have cmd_valid  in  1 and cmd_ready  out  1  host push handshake.
REQ-007 SHALL have cmd_type  in  1  0=draw, 1=clear.
REQ-008 SHALL have cmd_address  in  32, cmd_address_x/cmd_address_y/cmd_image_width/cmd_clear_color  in  16 each  command payload.
REQ-009 SHALL have cmd_width, cmd_x  in  $clog2(FB_WIDTH)+2, and cmd_height, cmd_y  in  $clog2(FB_HEIGHT)+2  excerpt geometry.
REQ-010 SHALL have ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color  out  (widths as matching cmd_*)  GPU control fields.
REQ-011 SHALL have ctrl_draw, ctrl_clear  out  1  GPU command strobes.
REQ-012 SHALL have ctrl_busy  in  1  GPU busy.
REQ-013 SHALL have level  out  $clog2(DEPTH)+1  FIFO occupancy; idle  out  1; cmd_done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL accept a command on an edge where cmd_valid && cmd_ready; cmd_ready SHALL equal (level != DEPTH).
REQ-015 SHALL store commands in FIFO order; no bypass: a pushed command is poppable no earlier than the following cycle.
REQ-016 SHALL run dispatch FSM IDLE -> SETUP -> STROBE -> WAIT -> IDLE.
REQ-017 IDLE: if level != 0 and ctrl_busy == 0, SHALL pop head into ctrl_* registers and go SETUP; otherwise stay.
REQ-018 SETUP: ctrl_* stable, both strobes low; SHALL go STROBE unconditionally.
REQ-019 STROBE: SHALL assert ctrl_draw (type 0) or ctrl_clear (type 1) for exactly one cycle, go WAIT.
REQ-020 WAIT: SHALL hold ctrl_* and strobes low; go IDLE and pulse cmd_done when ctrl_busy == 0.
REQ-021 ctrl_* SHALL change only on the IDLE pop edge; held through SETUP, STROBE and WAIT.
REQ-022 Strobes SHALL be low at least 2 cycles between consecutive strobes, and never both high.
REQ-023 Latency: push at edge t0 into empty queue, FSM IDLE, GPU not busy -> ctrl_* valid after t1, strobe high after t2, low after t3.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; push when full SHALL be ignored (ready low).
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-026 idle SHALL be 1 iff FSM in IDLE and level == 0.
REQ-027 Payload fields SHALL pass unmodified; clear commands SHALL still forward all fields.

Reset
REQ-028 On reset, SHALL asynchronously: FSM IDLE, FIFO emptied (level 0), all ctrl_* 0, strobes 0, cmd_done 0; cmd_ready 1 once reset deasserts.
REQ-029 Reset mid-dispatch SHALL drop queued and in-flight commands without issuing any strobe.

Structure
REQ-030 Package gpu_cmd_pkg SHALL hold command-type encoding, FSM state encoding and the command record layout/width constants derived from FB_WIDTH/FB_HEIGHT.
REQ-031 FIFO storage and pointers SHALL be sub-module gpu_cmd_fifo (synchronous, registered level).

Verification
REQ-032 Push one draw (address 0x1000, width 16, height 8, x 10, y 20), busy 0 -> ctrl fields valid after t1, single ctrl_draw pulse after t2, cmd_done when busy falls.
REQ-033 Push 5 commands with DEPTH 4, busy held 1 -> 4 accepted, cmd_ready 0, level 4; release busy -> all 4 issued in order with no strobe overlap.
REQ-034 Clear with color 0xF801 behind a draw -> ctrl_clear pulses only after busy low following the draw; ctrl_clear_color 0xF801 stable until WAIT exits.
REQ-035 Push on same edge as pop with level 2 -> level stays 2, order preserved.
REQ-036 Assert reset during WAIT with 3 queued -> level 0, ctrl_* 0, no strobe afterward, idle 1.
